// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Exhaustive self-test driver and checker for one 2-input library gate.
// On start it drives the four input vectors {b,a} = 00,01,10,11 in order.
// After each drive it waits a settle time and then samples the gate result.
// Each sample is compared with the expected function for GATE_TYPE, with
// BUBBLES_MASK input inversion applied before the function.
//
// Ports:
//   clock        in   single clock, all state on the rising edge
//   reset        in   asynchronous active-high clear of all state
//   tick         in   clock enable; FSM and counters advance only when high
//   start        in   begin a run (accepted only in IDLE with tick high)
//   dut_result   in   result output of the gate under test
//   drive_a      out  to gate input1 (vector bit 0)
//   drive_b      out  to gate input2 (vector bit 1)
//   busy         out  high from DRIVE through SAMPLE
//   done         out  single-clock pulse at end of run
//   pass         out  1 when the last run had no mismatches
//   fail_vector  out  {b,a} of the first mismatching vector, 2'b00 if none
//   error_count  out  mismatches in the last run, 0..4
//
// Optional macro GATE_CHECKER_SYNC_EN:
//   dut_result passes through a free-running 2-flop synchronizer, and the
//   settle time is extended by two enabled cycles to cover it.
module gate_vector_checker #(
  parameter int unsigned GATE_TYPE     = 3,
  parameter logic [1:0]  BUBBLES_MASK  = 2'b00,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       dut_result,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_vector,
  output logic [2:0] error_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  if ((SETTLE_CYCLES < 32'd1) || (SETTLE_CYCLES > 32'd15)) begin : g_settle_range_err
    $error("gate_vector_checker: SETTLE_CYCLES must be within 1..15");
  end

`ifdef GATE_CHECKER_SYNC_EN
  localparam int unsigned SYNC_EXTRA = 32'd2;
`else
  localparam int unsigned SYNC_EXTRA = 32'd0;
`endif

  // Counter runs from the load value down to zero, so the load is one less
  // than the number of settle cycles.
  localparam logic [4:0] SETTLE_LOAD = 5'(SETTLE_CYCLES + SYNC_EXTRA - 32'd1);
  localparam logic [2:0] GT_SEL      = GATE_TYPE[2:0];

  // Expected gate output for already-bubbled inputs; codes 6 and 7 act as NAND.
  function automatic logic gate_fn(input logic a, input logic b);
    case (GT_SEL)
      3'd0:    gate_fn = a & b;
      3'd1:    gate_fn = a | b;
      3'd2:    gate_fn = a ^ b;
      3'd3:    gate_fn = ~(a & b);
      3'd4:    gate_fn = ~(a | b);
      3'd5:    gate_fn = ~(a ^ b);
      default: gate_fn = ~(a & b);
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [1:0] index_q, index_d;
  logic [4:0] cnt_q, cnt_d;
  logic       drive_a_q, drive_a_d;
  logic       drive_b_q, drive_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [1:0] fail_vector_q, fail_vector_d;
  logic [2:0] error_count_q, error_count_d;
  logic       cmp_s;
  logic       mism_s;
  logic [2:0] err_nx_s;

`ifdef GATE_CHECKER_SYNC_EN
  logic [1:0] sync_q;

  // Free-running synchronizer for the gate result, independent of tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], dut_result};
    end
  end

  assign cmp_s = sync_q[1];
`else
  assign cmp_s = dut_result;
`endif

  assign mism_s   = cmp_s ^ gate_fn(index_q[0] ^ BUBBLES_MASK[0],
                                    index_q[1] ^ BUBBLES_MASK[1]);
  assign err_nx_s = (mism_s && (error_count_q != 3'd4)) ? (error_count_q + 3'd1)
                                                        : error_count_q;

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      index_q       <= 2'b00;
      cnt_q         <= 5'd0;
      drive_a_q     <= 1'b0;
      drive_b_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_vector_q <= 2'b00;
      error_count_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      cnt_q         <= cnt_d;
      drive_a_q     <= drive_a_d;
      drive_b_q     <= drive_b_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_vector_q <= fail_vector_d;
      error_count_q <= error_count_d;
    end
  end

  // Next-state logic; the FSM only moves on enabled cycles.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE:   state_d = start ? ST_DRIVE : ST_IDLE;
        ST_DRIVE:  state_d = ST_SETTLE;
        ST_SETTLE: state_d = (cnt_q == 5'd0) ? ST_SAMPLE : ST_SETTLE;
        ST_SAMPLE: state_d = (index_q == 2'd3) ? ST_DONE : ST_DRIVE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Next values of the registered outputs. They are computed on the
  // transition into a state so each output is visible while in that state.
  always_comb begin
    index_d       = index_q;
    cnt_d         = cnt_q;
    drive_a_d     = drive_a_q;
    drive_b_d     = drive_b_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    fail_vector_d = fail_vector_q;
    error_count_d = error_count_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            index_d       = 2'b00;
            drive_a_d     = 1'b0;
            drive_b_d     = 1'b0;
            busy_d        = 1'b1;
            pass_d        = 1'b0;
            fail_vector_d = 2'b00;
            error_count_d = 3'd0;
          end else begin
            busy_d = 1'b0;
          end
        end
        ST_DRIVE: cnt_d = SETTLE_LOAD;
        ST_SETTLE: begin
          if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_SAMPLE: begin
          error_count_d = err_nx_s;
          if (mism_s && (error_count_q == 3'd0)) begin
            fail_vector_d = index_q;
          end else begin
            fail_vector_d = fail_vector_q;
          end
          if (index_q == 2'd3) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_nx_s == 3'd0);
          end else begin
            index_d   = index_q + 2'd1;
            drive_a_d = index_d[0];
            drive_b_d = index_d[1];
          end
        end
        ST_DONE: begin
          drive_a_d = 1'b0;
          drive_b_d = 1'b0;
        end
        default: begin
          busy_d    = 1'b0;
          drive_a_d = 1'b0;
          drive_b_d = 1'b0;
        end
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  assign drive_a     = drive_a_q;
  assign drive_b     = drive_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_vector = fail_vector_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three checker instances with different
// gate types, bubble masks and settle times, each fed by an emulated gate.
module tb_gate_vector_checker;

  localparam int NI = 3;
  localparam int unsigned GT [NI] = '{3, 3, 0};
  localparam logic [1:0]  BMK[NI] = '{2'b00, 2'b01, 2'b00};
  localparam int unsigned SC [NI] = '{2, 2, 3};
`ifdef GATE_CHECKER_SYNC_EN
  localparam int SYNC_X = 2;
`else
  localparam int SYNC_X = 0;
`endif

  logic clock = 1'b0;
  logic reset, tick, start;
  logic da [NI];
  logic db [NI];
  logic bsy [NI];
  logic dn [NI];
  logic ps [NI];
  logic res [NI];
  logic [1:0] fv [NI];
  logic [2:0] ec [NI];

  // emulated gate: mode 0 = real gate(type, bubble mask), 1 = stuck 0, 2 = stuck 1
  int         em_mode [NI];
  int         em_type [NI];
  logic [1:0] em_bm   [NI];

  int errors = 0;
  int checks = 0;
  int lat [NI];

  // behavioural model state
  bit m_run [NI];
  bit m_dw  [NI];
  bit m_done[NI];
  bit m_pass[NI];
  int m_k   [NI];
  int m_err [NI];
  int m_fv  [NI];
  bit m_mis [NI][4];

  always #5 clock = ~clock;

  function automatic logic spec_f(input int gt, input logic a, input logic b);
    case (gt)
      0:       spec_f = a & b;
      1:       spec_f = a | b;
      2:       spec_f = a ^ b;
      4:       spec_f = ~(a | b);
      5:       spec_f = ~(a ^ b);
      default: spec_f = ~(a & b);
    endcase
  endfunction

  function automatic logic emul_out(input int mode, input int typ, input logic [1:0] bm,
                                    input logic a, input logic b);
    if (mode == 1) emul_out = 1'b0;
    else if (mode == 2) emul_out = 1'b1;
    else emul_out = spec_f(typ, a ^ bm[0], b ^ bm[1]);
  endfunction

  function automatic int per_of(input int i);
    per_of = int'(SC[i]) + 2 + SYNC_X;
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) res[i] = emul_out(em_mode[i], em_type[i], em_bm[i], da[i], db[i]);
  end

  gate_vector_checker #(.GATE_TYPE(GT[0]), .BUBBLES_MASK(BMK[0]), .SETTLE_CYCLES(SC[0])) u_dut0 (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .dut_result(res[0]),
    .drive_a(da[0]), .drive_b(db[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
    .fail_vector(fv[0]), .error_count(ec[0]));

  gate_vector_checker #(.GATE_TYPE(GT[1]), .BUBBLES_MASK(BMK[1]), .SETTLE_CYCLES(SC[1])) u_dut1 (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .dut_result(res[1]),
    .drive_a(da[1]), .drive_b(db[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
    .fail_vector(fv[1]), .error_count(ec[1]));

  gate_vector_checker #(.GATE_TYPE(GT[2]), .BUBBLES_MASK(BMK[2]), .SETTLE_CYCLES(SC[2])) u_dut2 (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .dut_result(res[2]),
    .drive_a(da[2]), .drive_b(db[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]),
    .fail_vector(fv[2]), .error_count(ec[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 1'b0; m_dw[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
      m_k[i] = 0; m_err[i] = 0; m_fv[i] = 0;
    end
  endtask

  // One enabled/disabled clock of the run model: a run is 4 vectors of
  // per_of(i) enabled cycles; the sample of vector v ends at offset (v+1)*per.
  task automatic model_step();
    int p;
    int v;
    for (int i = 0; i < NI; i++) begin
      p = per_of(i);
      m_done[i] = 1'b0;
      if (tick) begin
        if (m_dw[i]) begin
          m_dw[i] = 1'b0;
        end else if (m_run[i]) begin
          if (m_k[i] % p == 0) begin
            v = m_k[i] / p - 1;
            if (m_mis[i][v]) begin
              if (m_err[i] == 0) m_fv[i] = v;
              if (m_err[i] < 4) m_err[i]++;
            end
          end
          m_k[i]++;
          if (m_k[i] == 4 * p + 1) begin
            m_run[i] = 1'b0; m_dw[i] = 1'b1; m_done[i] = 1'b1; m_pass[i] = (m_err[i] == 0);
          end
        end else if (start) begin
          m_run[i] = 1'b1; m_k[i] = 1; m_err[i] = 0; m_fv[i] = 0; m_pass[i] = 1'b0;
          for (int vv = 0; vv < 4; vv++) begin
            logic [1:0] vb;
            vb = 2'(vv);
            m_mis[i][vv] = emul_out(em_mode[i], em_type[i], em_bm[i], vb[0], vb[1]) !=
                           spec_f(int'(GT[i]), vb[0] ^ BMK[i][0], vb[1] ^ BMK[i][1]);
          end
        end
      end
    end
  endtask

  // Compare process: advance model on each rising edge, check on falling edge.
  initial begin
    int vec;
    model_reset();
    forever begin
      @(posedge clock);
      if (reset) model_reset(); else model_step();
      @(negedge clock);
      if (reset) model_reset();
      for (int i = 0; i < NI; i++) begin
        vec = m_run[i] ? (m_k[i] - 1) / per_of(i) : (m_dw[i] ? 3 : 0);
        check($sformatf("busy[%0d]", i), int'(bsy[i]), int'(m_run[i]));
        check($sformatf("done[%0d]", i), int'(dn[i]), int'(m_done[i]));
        check($sformatf("pass[%0d]", i), int'(ps[i]), int'(m_pass[i]));
        check($sformatf("fail_vector[%0d]", i), int'(fv[i]), m_fv[i]);
        check($sformatf("error_count[%0d]", i), int'(ec[i]), m_err[i]);
        check($sformatf("drive_a[%0d]", i), int'(da[i]), vec % 2);
        check($sformatf("drive_b[%0d]", i), int'(db[i]), vec / 2);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic set_em(input int i, input int mode, input int typ, input logic [1:0] bm);
    em_mode[i] = mode; em_type[i] = typ; em_bm[i] = bm;
  endtask

  // Run once from IDLE with tick high one cycle in 'period'; record the
  // number of enabled edges from the start cycle to each done pulse.
  task automatic run_plan(input int period);
    bit got [NI];
    int n_en;
    bit prev;
    bit all_got;
    for (int i = 0; i < NI; i++) begin got[i] = 1'b0; lat[i] = -1; end
    start = 1'b1; tick = 1'b1; n_en = 0;
    for (int c = 0; c < 800; c++) begin
      prev = tick;
      cyc();
      if (prev) n_en++;
      start = (c == 6);
      tick = ((c + 1) % period == 0);
      all_got = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (!got[i] && dn[i]) begin got[i] = 1'b1; lat[i] = n_en; end
        all_got &= got[i];
      end
      if (all_got) break;
    end
    for (int i = 0; i < NI; i++)
      check($sformatf("run_length[%0d]", i), lat[i], 4 * per_of(i) + 1);
    start = 1'b0; tick = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic lit3(input string tag, input int i, input int p, input int e, input int f);
    check($sformatf("%s_pass[%0d]", tag, i), int'(ps[i]), p);
    check($sformatf("%s_errors[%0d]", tag, i), int'(ec[i]), e);
    check($sformatf("%s_fail_vector[%0d]", tag, i), int'(fv[i]), f);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    set_em(0, 0, 3, 2'b00); set_em(1, 0, 3, 2'b01); set_em(2, 2, 0, 2'b00);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("reset_busy", int'(bsy[0]), 0);
    check("reset_done", int'(dn[0]), 0);
    check("reset_drive", int'({db[0], da[0]}), 0);
    lit3("reset", 0, 0, 0, 0);

    // matching NAND gates and a stuck-at-1 against AND
    run_plan(1);
    lit3("runA", 0, 1, 0, 0);
    lit3("runA", 1, 1, 0, 0);
    lit3("runA", 2, 0, 3, 0);

    // stuck-at-0 NAND, wrong bubble mask, real AND; slow tick
    set_em(0, 1, 3, 2'b00); set_em(1, 0, 3, 2'b00); set_em(2, 0, 0, 2'b00);
    run_plan(3);
    lit3("runB", 0, 0, 3, 0);
    lit3("runB", 1, 0, 2, 2);
    lit3("runB", 2, 1, 0, 0);

    // reset during SETTLE of vector 2, then a clean run
    set_em(0, 0, 3, 2'b00); set_em(1, 0, 3, 2'b01); set_em(2, 0, 0, 2'b00);
    start = 1'b1; tick = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2 * per_of(0) + 1) cyc();
    check("settle_v2_drive", int'({db[0], da[0]}), 2);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("abort_outputs[%0d]", i),
            int'({bsy[i], dn[i], ps[i], fv[i], ec[i], da[i], db[i]}), 0);
    end
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    run_plan(1);
    for (int i = 0; i < NI; i++) lit3("rerun", i, 1, 0, 0);

    // randomized segments checked by the model
    for (int s = 0; s < 12; s++) begin
      int dens;
      reset = 1'b1;
      for (int i = 0; i < NI; i++)
        set_em(i, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
      dens = int'($urandom_range(1, 4));
      cyc(); cyc();
      reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
        tick  = ($urandom_range(0, 3) < dens);
        start = ($urandom_range(0, 5) == 0);
        reset = ($urandom_range(0, 299) == 0);
        cyc();
      end
      reset = 1'b0;
    end
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
